// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op codes
// and the ALU Signal codes it drives on the shared EX-stage ALU.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide, given the ALU
// result for this cycle. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] mul_sum;
  logic             mul_carry;

  // Partial remainder shifted left by one; the bit pushed out of hi is kept
  // separately because a set msb means the subtract always succeeds.
  assign div_rem = {hi[WIDTH-2:0], lo[WIDTH-1]};

  always_comb begin
    mul_sum   = lo[0] ? alu_result : hi;
    mul_carry = lo[0] & alu_cout;
    hi_next   = hi;
    lo_next   = lo;
    if (div_mode) begin
      if (hi[WIDTH-1] || alu_cout) begin
        hi_next = alu_result;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_rem;
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = {mul_carry, mul_sum[WIDTH-1:1]};
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller that borrows the shared EX-stage ALU for
// one step per cycle while busy is high; results accumulate in hi/lo.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_signal,
  output logic             alu_invertb,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, dsor;
  logic [CNT_W-1:0] cnt;
  logic             accept, stepping;
  logic [WIDTH-1:0] div_rem, hi_step, lo_step;

  // Handshake: start is taken on any edge where the state is IDLE or DONE
  // (no ready output; busy=0 means a start will be accepted). While busy,
  // start is ignored and operands are not re-sampled. done pulses for one
  // cycle with hi/lo final.
  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign stepping  = (state == ST_MUL) || (state == ST_DIV);
  assign busy      = stepping;
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode   (state == ST_DIV),
    .hi         (hi),
    .lo         (lo),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .div_rem    (div_rem),
    .hi_next    (hi_step),
    .lo_next    (lo_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nx = ST_IDLE;
        if (accept) begin
          if (op == OP_MULTU)    state_nx = ST_MUL;
          else if (src_b == '0) state_nx = ST_DONE;
          else                   state_nx = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (cnt == '0) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_signal  = ALU_AND;
    alu_invertb = 1'b0;
    alu_cin     = 1'b0;
    if (state == ST_MUL) begin
      alu_a      = hi;
      alu_b      = mcand;
      alu_signal = ALU_ADD;
    end else if (state == ST_DIV) begin
      // r + ~dsor + 1: carry out set means r >= dsor.
      alu_a       = div_rem;
      alu_b       = dsor;
      alu_signal  = ALU_ADD;
      alu_invertb = 1'b1;
      alu_cin     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      dsor  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= src_a;
      dsor  <= src_b;
      cnt   <= CNT_W'(WIDTH - 1);
      if (op == OP_MULTU) begin
        hi <= '0;
        lo <= src_b;
      end else if (src_b == '0) begin
        hi <= src_a;
        lo <= '1;
      end else begin
        hi <= '0;
        lo <= src_a;
      end
    end else if (stepping) begin
      hi  <= hi_step;
      lo  <= lo_step;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: behavioural ALU beside the DUT, directed and
// random MULTU/DIVU operations checked against plain-arithmetic results.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_signal, state_dbg;
  logic         alu_invertb, alu_cin, alu_cout;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];
  int             exp_lat_q[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_signal  (alu_signal),
    .alu_invertb (alu_invertb),
    .alu_cin     (alu_cin),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .state_dbg   (state_dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Shared ALU model: AND/OR/ADD/SLT with B-invert and carry-in.
  logic [W-1:0] alu_bb;
  logic [W:0]   alu_sum;
  always_comb begin
    alu_bb     = alu_invertb ? ~alu_b : alu_b;
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_bb} + {{W{1'b0}}, alu_cin};
    alu_cout   = alu_sum[W];
    alu_result = '0;
    case (alu_signal)
      2'b00:   alu_result = alu_a & alu_bb;
      2'b01:   alu_result = alu_a | alu_bb;
      2'b10:   alu_result = alu_sum[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
    endcase
  end

  function automatic logic [2*W-1:0] ref_result(input logic o, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    if (o == OP_MULTU) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (b == '0)       return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present an op for one clock edge; caller is at a negedge.
  task automatic start_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit track);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (track) begin
      exp_q.push_back(ref_result(o, a, b));
      exp_lat_q.push_back((o == OP_DIVU && b == '0) ? 1 : W + 1);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Scoreboard: wait (bounded) for done, then compare latency, busy time
  // and result. Returns at the negedge inside the done cycle.
  task automatic wait_done(input string tag, input bit poke_start);
    int lat = 0;
    int busy_cnt = 0;
    int exp_lat = 0;
    logic [2*W-1:0] exp = '0;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && k == 5) begin
        start = 1'b1;
        op    = ~op;
        src_a = $urandom;
        src_b = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      exp     = exp_q.pop_front();
      exp_lat = exp_lat_q.pop_front();
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    int done_seen;
    logic [2*W-1:0] held;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    check("reset_hilo", {hi, lo}, '0);
    check("reset_busy_done", 64'({busy, done}), 64'd0);
    check("idle_alu_ab", {alu_a, alu_b}, '0);
    check("idle_alu_ctl", 64'({alu_signal, alu_invertb, alu_cin}), 64'd0);
    rst_n = 1'b1;

    // Directed operations
    @(negedge clk); start_op(OP_MULTU, 32'd7, 32'd6, 1'b1);                wait_done("mul_7x6", 1'b0);
    @(negedge clk); start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);  wait_done("mul_max", 1'b0);
    @(negedge clk); start_op(OP_DIVU, 32'd100, 32'd7, 1'b1);               wait_done("div_100_7", 1'b0);
    @(negedge clk); start_op(OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 1'b1);   wait_done("div_msb", 1'b0);
    @(negedge clk); start_op(OP_DIVU, 32'h1234, 32'h0, 1'b1);              wait_done("div_zero", 1'b0);
    @(negedge clk);
    check("hold_after_div_zero", {hi, lo}, {32'h1234, 32'hFFFFFFFF});

    // Reset in the middle of a multiply: no result, no done pulse.
    start_op(OP_MULTU, 32'hDEAD, 32'hBEEF, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_state", 64'(state_dbg), 64'(ST_IDLE));
    check("midreset_hilo", {hi, lo}, '0);
    check("midreset_busy_done", 64'({busy, done}), 64'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);

    // Start while busy is ignored; start in the done cycle chains straight on.
    start_op(OP_DIVU, 32'd1000003, 32'd97, 1'b1);
    wait_done("div_poked", 1'b1);
    start_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done("b2b_mul", 1'b0);
    start_op(OP_DIVU, 32'h55, 32'h0, 1'b1);
    wait_done("b2b_div_zero", 1'b0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      logic o;
      logic [W-1:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      @(negedge clk);
      start_op(o, a, b, 1'b1);
      wait_done($sformatf("rand%0d", i), 1'b0);
      held = ref_result(o, a, b);
      @(negedge clk);
      check($sformatf("rand%0d_hold", i), {hi, lo}, held);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
